// File: rtl/scr1_pipe_lsu_mo_pkg.sv
// Shared types and constants for the multi-outstanding LSU: commands, memory codes,
// exception codes, FSM states and the tracking-FIFO entry.
package scr1_pipe_lsu_mo_pkg;

    localparam int unsigned SCR1_EXC_CODE_WIDTH_E = 4;
    localparam int unsigned SCR1_LSU_CMD_WIDTH_E  = 4;

    typedef enum logic [SCR1_LSU_CMD_WIDTH_E-1:0] {
        SCR1_LSU_CMD_NONE = 4'd0,
        SCR1_LSU_CMD_LB   = 4'd1,
        SCR1_LSU_CMD_LH   = 4'd2,
        SCR1_LSU_CMD_LW   = 4'd3,
        SCR1_LSU_CMD_LBU  = 4'd4,
        SCR1_LSU_CMD_LHU  = 4'd5,
        SCR1_LSU_CMD_SB   = 4'd6,
        SCR1_LSU_CMD_SH   = 4'd7,
        SCR1_LSU_CMD_SW   = 4'd8
    } type_scr1_lsu_cmd_sel_e;

    localparam logic [SCR1_EXC_CODE_WIDTH_E-1:0] SCR1_EXC_CODE_INSTR_MISALIGN   = 4'd0;
    localparam logic [SCR1_EXC_CODE_WIDTH_E-1:0] SCR1_EXC_CODE_LD_ADDR_MISALIGN = 4'd4;
    localparam logic [SCR1_EXC_CODE_WIDTH_E-1:0] SCR1_EXC_CODE_LD_ACCESS_FAULT  = 4'd5;
    localparam logic [SCR1_EXC_CODE_WIDTH_E-1:0] SCR1_EXC_CODE_ST_ADDR_MISALIGN = 4'd6;
    localparam logic [SCR1_EXC_CODE_WIDTH_E-1:0] SCR1_EXC_CODE_ST_ACCESS_FAULT  = 4'd7;

    localparam logic       SCR1_MEM_CMD_RD       = 1'b0;
    localparam logic       SCR1_MEM_CMD_WR       = 1'b1;
    localparam logic [1:0] SCR1_MEM_WIDTH_BYTE   = 2'b00;
    localparam logic [1:0] SCR1_MEM_WIDTH_HWORD  = 2'b01;
    localparam logic [1:0] SCR1_MEM_WIDTH_WORD   = 2'b10;
    localparam logic [1:0] SCR1_MEM_RESP_NOTRDY  = 2'b00;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK  = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER  = 2'b10;

    typedef enum logic [1:0] {
        SCR1_LSU_MO_IDLE   = 2'd0,
        SCR1_LSU_MO_ACTIVE = 2'd1,
        SCR1_LSU_MO_DRAIN  = 2'd2
    } type_scr1_lsu_mo_fsm_e;

    typedef struct packed {
        type_scr1_lsu_cmd_sel_e cmd;
        logic [1:0]             off;
    } type_scr1_lsu_trk_s;

    function automatic logic scr1_lsu_is_store(input type_scr1_lsu_cmd_sel_e cmd);
        return (cmd == SCR1_LSU_CMD_SB) || (cmd == SCR1_LSU_CMD_SH) || (cmd == SCR1_LSU_CMD_SW);
    endfunction

    function automatic logic [1:0] scr1_lsu_mem_width(input type_scr1_lsu_cmd_sel_e cmd);
        case (cmd)
            SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_SB: return SCR1_MEM_WIDTH_BYTE;
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: return SCR1_MEM_WIDTH_HWORD;
            default:                                            return SCR1_MEM_WIDTH_WORD;
        endcase
    endfunction

endpackage

// File: rtl/scr1_lsu_trk_fifo.sv
// In-order tracking FIFO holding {cmd, byte offset} of every DMEM request still
// awaiting its response.
module scr1_lsu_trk_fifo
    import scr1_pipe_lsu_mo_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  type_scr1_lsu_trk_s i_wdata,
    input  logic               i_pop,
    output type_scr1_lsu_trk_s o_head,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    type_scr1_lsu_trk_s r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    // Wrap explicitly so non-power-of-two pointer ranges stay in bounds
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (i_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(i_pop && o_empty));
`endif

endmodule

// File: rtl/scr1_pipe_lsu_mo.sv
// Load/store unit with up to OUTST_DEPTH in-flight DMEM requests, in-order completion,
// precise misalign/access-fault exceptions and a drain phase after a faulting response.
module scr1_pipe_lsu_mo
    import scr1_pipe_lsu_mo_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = 2,
    parameter bit          LANE_ALIGN  = 1'b1
)
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              exu2lsu_req_i,
    input  type_scr1_lsu_cmd_sel_e            exu2lsu_cmd_i,
    input  logic [31:0]                       exu2lsu_addr_i,
    input  logic [31:0]                       exu2lsu_sdata_i,
    output logic                              lsu2exu_req_ack_o,
    output logic                              lsu2exu_rdy_o,
    output logic [31:0]                       lsu2exu_ldata_o,
    output logic                              lsu2exu_exc_o,
    output logic [SCR1_EXC_CODE_WIDTH_E-1:0]  lsu2exu_exc_code_o,
    output logic                              lsu2exu_busy_o,
    output logic                              lsu2dmem_req_o,
    output logic                              lsu2dmem_cmd_o,
    output logic [1:0]                        lsu2dmem_width_o,
    output logic [31:0]                       lsu2dmem_addr_o,
    output logic [31:0]                       lsu2dmem_wdata_o,
    input  logic                              dmem2lsu_req_ack_i,
    input  logic [31:0]                       dmem2lsu_rdata_i,
    input  logic [1:0]                        dmem2lsu_resp_i
);

    localparam int unsigned CNT_W = $clog2(OUTST_DEPTH + 1);

    type_scr1_lsu_mo_fsm_e r_state;
    type_scr1_lsu_mo_fsm_e w_state_next;
    type_scr1_lsu_trk_s    w_push_data;
    type_scr1_lsu_trk_s    w_head;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_width;
    logic                  w_misalign;
    logic                  w_dmem_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rdy;
    logic                  w_acc_fault;
    logic                  w_mis_exc;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ldata;
    logic [31:0]           w_wdata;
    logic [SCR1_EXC_CODE_WIDTH_E-1:0] w_exc_code;

    scr1_lsu_trk_fifo #(.DEPTH(OUTST_DEPTH)) u_trk_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Request path: full is the registered count, so a same-cycle pop frees no slot
    assign w_width     = scr1_lsu_mem_width(exu2lsu_cmd_i);
    assign w_misalign  = ((w_width == SCR1_MEM_WIDTH_HWORD) && exu2lsu_addr_i[0])
                       || ((w_width == SCR1_MEM_WIDTH_WORD) && (exu2lsu_addr_i[1:0] != 2'b00));
    assign w_dmem_req  = rst_n && exu2lsu_req_i && !w_misalign && !w_full
                       && (r_state != SCR1_LSU_MO_DRAIN);
    assign w_push      = w_dmem_req && dmem2lsu_req_ack_i;
    assign w_push_data = '{cmd: exu2lsu_cmd_i, off: exu2lsu_addr_i[1:0]};

    // Misalign is only reported once everything older has retired
    assign w_mis_exc   = rst_n && exu2lsu_req_i && w_misalign && w_empty
                       && (r_state == SCR1_LSU_MO_IDLE);

    assign w_pop        = !w_empty && ((dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_OK)
                                    || (dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER));
    assign w_rdy        = w_pop && (r_state == SCR1_LSU_MO_ACTIVE);
    assign w_acc_fault  = w_rdy && (dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER);
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCR1_LSU_MO_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCR1_LSU_MO_IDLE: begin
                if (w_push) w_state_next = SCR1_LSU_MO_ACTIVE;
            end
            SCR1_LSU_MO_ACTIVE: begin
                if (w_count_next == '0)  w_state_next = SCR1_LSU_MO_IDLE;
                else if (w_acc_fault)    w_state_next = SCR1_LSU_MO_DRAIN;
            end
            SCR1_LSU_MO_DRAIN: begin
                if (w_count_next == '0)  w_state_next = SCR1_LSU_MO_IDLE;
            end
            default: w_state_next = SCR1_LSU_MO_IDLE;
        endcase
    end

    // Load lane select and extension, keyed by the head entry of the tracking FIFO
    always_comb begin
        w_byte  = dmem2lsu_rdata_i[7:0];
        w_half  = dmem2lsu_rdata_i[15:0];
        if (LANE_ALIGN) begin
            w_byte = dmem2lsu_rdata_i[{w_head.off, 3'b000} +: 8];
            w_half = dmem2lsu_rdata_i[{w_head.off[1], 4'b0000} +: 16];
        end
        w_ldata = dmem2lsu_rdata_i;
        case (w_head.cmd)
            SCR1_LSU_CMD_LB:  w_ldata = {{24{w_byte[7]}}, w_byte};
            SCR1_LSU_CMD_LBU: w_ldata = {24'h000000, w_byte};
            SCR1_LSU_CMD_LH:  w_ldata = {{16{w_half[15]}}, w_half};
            SCR1_LSU_CMD_LHU: w_ldata = {16'h0000, w_half};
            default:          w_ldata = dmem2lsu_rdata_i;
        endcase
    end

    always_comb begin
        w_wdata = exu2lsu_sdata_i;
        if (LANE_ALIGN) begin
            case (exu2lsu_cmd_i)
                SCR1_LSU_CMD_SB: w_wdata = {4{exu2lsu_sdata_i[7:0]}};
                SCR1_LSU_CMD_SH: w_wdata = {2{exu2lsu_sdata_i[15:0]}};
                default:         w_wdata = exu2lsu_sdata_i;
            endcase
        end
    end

    // Access fault outranks misalign; idle code is INSTR_MISALIGN (zero)
    always_comb begin
        w_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
        if (w_acc_fault) begin
            w_exc_code = scr1_lsu_is_store(w_head.cmd) ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                                       : SCR1_EXC_CODE_LD_ACCESS_FAULT;
        end else if (w_mis_exc) begin
            w_exc_code = scr1_lsu_is_store(exu2lsu_cmd_i) ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                                          : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end
    end

    assign lsu2exu_req_ack_o  = w_push;
    assign lsu2exu_rdy_o      = w_rdy;
    assign lsu2exu_ldata_o    = rst_n ? w_ldata : 32'h0;
    assign lsu2exu_exc_o      = w_acc_fault || w_mis_exc;
    assign lsu2exu_exc_code_o = w_exc_code;
    assign lsu2exu_busy_o     = rst_n && (!w_empty || (r_state == SCR1_LSU_MO_DRAIN));
    assign lsu2dmem_req_o     = w_dmem_req;
    assign lsu2dmem_cmd_o     = (rst_n && scr1_lsu_is_store(exu2lsu_cmd_i)) ? SCR1_MEM_CMD_WR
                                                                            : SCR1_MEM_CMD_RD;
    assign lsu2dmem_width_o   = rst_n ? w_width : 2'b00;
    assign lsu2dmem_addr_o    = rst_n ? exu2lsu_addr_i : 32'h0;
    assign lsu2dmem_wdata_o   = rst_n ? w_wdata : 32'h0;

`ifndef SYNTHESIS
    a_exc_source: assert property (@(posedge clk) disable iff (!rst_n)
        lsu2exu_exc_o |-> (exu2lsu_req_i || (dmem2lsu_resp_i == SCR1_MEM_RESP_RDY_ER)));
    a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({exu2lsu_req_i, dmem2lsu_req_ack_i, dmem2lsu_resp_i,
                     lsu2dmem_req_o, lsu2exu_rdy_o, lsu2exu_exc_o, lsu2exu_busy_o}));
`endif

endmodule

// File: tb/tb_scr1_pipe_lsu_mo.sv
// Directed bench for scr1_pipe_lsu_mo: a depth-2 and a depth-4 instance share stimulus;
// each scenario checks only the instance it targets.
module tb_scr1_pipe_lsu_mo;
    import scr1_pipe_lsu_mo_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   req;
    type_scr1_lsu_cmd_sel_e cmd;
    logic [31:0]            addr;
    logic [31:0]            sdata;
    logic                   dack;
    logic [31:0]            rdata;
    logic [1:0]             resp;

    logic        ack_o, rdy_o, exc_o, busy_o, dreq_o, dcmd_o;
    logic [31:0] ldata_o, daddr_o, wdata_o;
    logic [3:0]  code_o;
    logic [1:0]  width_o;

    logic        ack4, rdy4, exc4, busy4, dreq4, dcmd4;
    logic [31:0] ldata4, daddr4, wdata4;
    logic [3:0]  code4;
    logic [1:0]  width4;

    int n_checks;
    int n_fail;

    scr1_pipe_lsu_mo #(.OUTST_DEPTH(2), .LANE_ALIGN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .exu2lsu_req_i(req), .exu2lsu_cmd_i(cmd), .exu2lsu_addr_i(addr), .exu2lsu_sdata_i(sdata),
        .lsu2exu_req_ack_o(ack_o), .lsu2exu_rdy_o(rdy_o), .lsu2exu_ldata_o(ldata_o),
        .lsu2exu_exc_o(exc_o), .lsu2exu_exc_code_o(code_o), .lsu2exu_busy_o(busy_o),
        .lsu2dmem_req_o(dreq_o), .lsu2dmem_cmd_o(dcmd_o), .lsu2dmem_width_o(width_o),
        .lsu2dmem_addr_o(daddr_o), .lsu2dmem_wdata_o(wdata_o),
        .dmem2lsu_req_ack_i(dack), .dmem2lsu_rdata_i(rdata), .dmem2lsu_resp_i(resp)
    );

    scr1_pipe_lsu_mo #(.OUTST_DEPTH(4), .LANE_ALIGN(1'b1)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .exu2lsu_req_i(req), .exu2lsu_cmd_i(cmd), .exu2lsu_addr_i(addr), .exu2lsu_sdata_i(sdata),
        .lsu2exu_req_ack_o(ack4), .lsu2exu_rdy_o(rdy4), .lsu2exu_ldata_o(ldata4),
        .lsu2exu_exc_o(exc4), .lsu2exu_exc_code_o(code4), .lsu2exu_busy_o(busy4),
        .lsu2dmem_req_o(dreq4), .lsu2dmem_cmd_o(dcmd4), .lsu2dmem_width_o(width4),
        .lsu2dmem_addr_o(daddr4), .lsu2dmem_wdata_o(wdata4),
        .dmem2lsu_req_ack_i(dack), .dmem2lsu_rdata_i(rdata), .dmem2lsu_resp_i(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input type_scr1_lsu_cmd_sel_e c, input logic [31:0] a,
                         input logic [31:0] s, input logic [1:0] rs, input logic [31:0] rd);
        req   = r;
        cmd   = c;
        addr  = a;
        sdata = s;
        resp  = rs;
        rdata = rd;
    endtask

    localparam logic [1:0] NR = SCR1_MEM_RESP_NOTRDY;
    localparam logic [1:0] OK = SCR1_MEM_RESP_RDY_OK;
    localparam logic [1:0] ER = SCR1_MEM_RESP_RDY_ER;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        dack     = 1'b1;
        drive(1'b1, SCR1_LSU_CMD_LW, 32'h100, 32'h0, NR, 32'h0);
        #2;
        check("rst_req",  32'(dreq_o), 32'h0);
        check("rst_ack",  32'(ack_o),  32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_rdy",  32'(rdy_o),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0);

        // Back-to-back LW, third held while full, in-order data
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h100, 32'h0, NR, 32'h0); #1;
        check("b2b_req0", 32'(dreq_o), 32'h1);
        check("b2b_ack0", 32'(ack_o),  32'h1);
        check("b2b_busy0", 32'(busy_o), 32'h0);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h104, 32'h0, NR, 32'h0); #1;
        check("b2b_ack1", 32'(ack_o), 32'h1);
        check("b2b_busy1", 32'(busy_o), 32'h1);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h108, 32'h0, NR, 32'h0); #1;
        check("full_hold_req", 32'(dreq_o), 32'h0);
        check("full_hold_ack", 32'(ack_o),  32'h0);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h108, 32'h0, OK, 32'h11111111); #1;
        check("full_no_bypass", 32'(dreq_o), 32'h0);
        check("resp0_rdy", 32'(rdy_o), 32'h1);
        check("resp0_data", ldata_o, 32'h11111111);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h108, 32'h0, OK, 32'h22222222); #1;
        check("third_accept", 32'(ack_o), 32'h1);
        check("resp1_rdy", 32'(rdy_o), 32'h1);
        check("resp1_data", ldata_o, 32'h22222222);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h33333333); #1;
        check("resp2_data", ldata_o, 32'h33333333);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0); #1;
        check("b2b_idle_busy", 32'(busy_o), 32'h0);

        // Load lane extraction and extension
        tick(); drive(1'b1, SCR1_LSU_CMD_LB, 32'h103, 32'h0, NR, 32'h0); #1;
        check("lb_width", 32'(width_o), 32'(SCR1_MEM_WIDTH_BYTE));
        check("lb_cmd", 32'(dcmd_o), 32'(SCR1_MEM_CMD_RD));
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h80FF0000); #1;
        check("lb_data", ldata_o, 32'hFFFFFF80);
        tick(); drive(1'b1, SCR1_LSU_CMD_LHU, 32'h102, 32'h0, NR, 32'h0); #1;
        check("lhu_width", 32'(width_o), 32'(SCR1_MEM_WIDTH_HWORD));
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h80FF0000); #1;
        check("lhu_data", ldata_o, 32'h000080FF);
        tick(); drive(1'b1, SCR1_LSU_CMD_LH, 32'h100, 32'h0, NR, 32'h0); #1;
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h12348001); #1;
        check("lh_data", ldata_o, 32'hFFFF8001);
        tick(); drive(1'b1, SCR1_LSU_CMD_LBU, 32'h101, 32'h0, NR, 32'h0); #1;
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h0000F500); #1;
        check("lbu_data", ldata_o, 32'h000000F5);

        // Store lane replication
        tick(); drive(1'b1, SCR1_LSU_CMD_SB, 32'h1, 32'h000000A5, NR, 32'h0); #1;
        check("sb_wdata", wdata_o, 32'hA5A5A5A5);
        check("sb_width", 32'(width_o), 32'(SCR1_MEM_WIDTH_BYTE));
        check("sb_cmd", 32'(dcmd_o), 32'(SCR1_MEM_CMD_WR));
        check("sb_addr", daddr_o, 32'h1);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h0); #1;
        check("sb_rdy", 32'(rdy_o), 32'h1);
        tick(); drive(1'b1, SCR1_LSU_CMD_SH, 32'h2, 32'h1234BEEF, NR, 32'h0); #1;
        check("sh_wdata", wdata_o, 32'hBEEFBEEF);
        check("sh_width", 32'(width_o), 32'(SCR1_MEM_WIDTH_HWORD));
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h0); #1;

        // Misaligned request held behind an outstanding LW
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h100, 32'h0, NR, 32'h0); #1;
        check("mis_pre_ack", 32'(ack_o), 32'h1);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h102, 32'h0, NR, 32'h0); #1;
        check("mis_held_exc", 32'(exc_o), 32'h0);
        check("mis_held_req", 32'(dreq_o), 32'h0);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h102, 32'h0, OK, 32'hCAFE0001); #1;
        check("mis_older_rdy", 32'(rdy_o), 32'h1);
        check("mis_older_exc", 32'(exc_o), 32'h0);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h102, 32'h0, NR, 32'h0); #1;
        check("mis_exc", 32'(exc_o), 32'h1);
        check("mis_code", 32'(code_o), 32'(SCR1_EXC_CODE_LD_ADDR_MISALIGN));
        check("mis_req", 32'(dreq_o), 32'h0);
        check("mis_rdy", 32'(rdy_o), 32'h0);
        tick(); drive(1'b1, SCR1_LSU_CMD_SW, 32'h3, 32'h0, NR, 32'h0); #1;
        check("sw_mis_code", 32'(code_o), 32'(SCR1_EXC_CODE_ST_ADDR_MISALIGN));
        tick(); drive(1'b1, SCR1_LSU_CMD_LH, 32'h101, 32'h0, NR, 32'h0); #1;
        check("lh_mis_code", 32'(code_o), 32'(SCR1_EXC_CODE_LD_ADDR_MISALIGN));

        // Store access fault with nothing else outstanding
        tick(); drive(1'b1, SCR1_LSU_CMD_SW, 32'h400, 32'hDEADBEEF, NR, 32'h0); #1;
        check("sw_wdata", wdata_o, 32'hDEADBEEF);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, ER, 32'h0); #1;
        check("st_af_rdy", 32'(rdy_o), 32'h1);
        check("st_af_code", 32'(code_o), 32'(SCR1_EXC_CODE_ST_ACCESS_FAULT));
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0); #1;
        check("st_af_busy", 32'(busy_o), 32'h0);
        check("idle_code", 32'(code_o), 32'(SCR1_EXC_CODE_INSTR_MISALIGN));

        // Depth-4: fault on the first of three, then silent drain
        tick(); rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1;
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h200, 32'h0, NR, 32'h0); #1;
        check("d4_ack0", 32'(ack4), 32'h1);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h204, 32'h0, NR, 32'h0); #1;
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h208, 32'h0, NR, 32'h0); #1;
        check("d4_ack2", 32'(ack4), 32'h1);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, ER, 32'h0); #1;
        check("d4_af_rdy", 32'(rdy4), 32'h1);
        check("d4_af_exc", 32'(exc4), 32'h1);
        check("d4_af_code", 32'(code4), 32'(SCR1_EXC_CODE_LD_ACCESS_FAULT));
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h300, 32'h0, OK, 32'h0); #1;
        check("d4_drain_block", 32'(dreq4), 32'h0);
        check("d4_drain_rdy0", 32'(rdy4), 32'h0);
        check("d4_drain_exc", 32'(exc4), 32'h0);
        check("d4_drain_busy", 32'(busy4), 32'h1);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h0); #1;
        check("d4_drain_rdy1", 32'(rdy4), 32'h0);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0); #1;
        check("d4_idle_busy", 32'(busy4), 32'h0);

        // Reset with two outstanding discards them
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h500, 32'h0, NR, 32'h0); #1;
        check("rr_ack0", 32'(ack_o), 32'h1);
        tick(); drive(1'b1, SCR1_LSU_CMD_LW, 32'h504, 32'h0, NR, 32'h0); #1;
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0); #1;
        check("rr_busy_pre", 32'(busy_o), 32'h1);
        tick(); rst_n = 1'b0; #1;
        check("rr_busy_rst", 32'(busy_o), 32'h0);
        tick(); rst_n = 1'b1; drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, OK, 32'h55555555); #1;
        check("rr_late_rdy", 32'(rdy_o), 32'h0);
        check("rr_late_exc", 32'(exc_o), 32'h0);
        tick(); drive(1'b0, SCR1_LSU_CMD_LW, 32'h0, 32'h0, NR, 32'h0); #1;
        check("rr_busy_post", 32'(busy_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
